id_ex_reg: RTL

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 98 +++++++++
 1 files changed

// File: rtl/id_ex_reg.sv
// id_ex_reg: decode-to-execute pipeline register with operand forwarding, load-use stall, flush and backpressure
// Ports: clk/rst; decode side id_* (valid/ready handshake, operands, control);
// forwarding ex_fwd_*/wb_fwd_*; execute side ex_valid/ex_ready, op1/op2, alu_type, ex_rd_*, ex_pc; flush.
package defines;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_type;
endpackage

module id_ex_reg (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [31:0]         id_pc,
  input  logic [31:0]         id_rs1_data,
  input  logic [31:0]         id_rs2_data,
  input  logic [31:0]         id_imm,
  input  logic [4:0]          id_rs1_addr,
  input  logic [4:0]          id_rs2_addr,
  input  logic [4:0]          id_rd_addr,
  input  logic                id_rd_we,
  input  logic                id_op1_sel,
  input  logic                id_op2_sel,
  input  defines::alu_op_type id_alu_type,
  input  logic                ex_fwd_we,
  input  logic [4:0]          ex_fwd_rd,
  input  logic [31:0]         ex_fwd_data,
  input  logic                ex_fwd_is_load,
  input  logic                wb_fwd_we,
  input  logic [4:0]          wb_fwd_rd,
  input  logic [31:0]         wb_fwd_data,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [31:0]         op1,
  output logic [31:0]         op2,
  output defines::alu_op_type alu_type,
  output logic [4:0]          ex_rd_addr,
  output logic                ex_rd_we,
  output logic [31:0]         ex_pc,
  input  logic                flush
);
  logic                valid_q, valid_d;
  logic [31:0]         op1_q, op1_d, op2_q, op2_d, pc_q, pc_d;
  defines::alu_op_type alu_q, alu_d;
  logic [4:0]          rd_q, rd_d;
  logic                we_q, we_d;
  logic                load_use, capture, ex_hit1, ex_hit2, wb_hit1, wb_hit2;
  logic [31:0]         rs1_res, rs2_res;
  always_comb begin
    ex_hit1  = ex_fwd_we && ex_fwd_rd == id_rs1_addr && id_rs1_addr != 5'd0;
    ex_hit2  = ex_fwd_we && ex_fwd_rd == id_rs2_addr && id_rs2_addr != 5'd0;
    wb_hit1  = wb_fwd_we && wb_fwd_rd == id_rs1_addr && id_rs1_addr != 5'd0;
    wb_hit2  = wb_fwd_we && wb_fwd_rd == id_rs2_addr && id_rs2_addr != 5'd0;
    // a load result is not ready yet, so a dependent operand must stall instead of forwarding
    load_use = id_valid && ex_fwd_is_load &&
               ((!id_op1_sel && ex_hit1) || (!id_op2_sel && ex_hit2));
    id_ready = !rst && (!valid_q || ex_ready) && !load_use && !flush;
    capture  = id_valid && id_ready;
    rs1_res  = (ex_hit1 && !ex_fwd_is_load) ? ex_fwd_data : wb_hit1 ? wb_fwd_data : id_rs1_data;
    rs2_res  = (ex_hit2 && !ex_fwd_is_load) ? ex_fwd_data : wb_hit2 ? wb_fwd_data : id_rs2_data;
    valid_d  = flush ? 1'b0 : capture ? 1'b1 : (valid_q && ex_ready) ? 1'b0 : valid_q;
    op1_d    = capture ? (id_op1_sel ? id_pc : rs1_res) : op1_q;
    op2_d    = capture ? (id_op2_sel ? id_imm : rs2_res) : op2_q;
    pc_d     = capture ? id_pc : pc_q;
    alu_d    = capture ? id_alu_type : alu_q;
    rd_d     = capture ? id_rd_addr : rd_q;
    we_d     = capture ? id_rd_we : we_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      pc_q    <= '0;
      alu_q   <= defines::ALU_ADD;
      rd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
    end
  end
  assign ex_valid   = valid_q;
  assign op1        = op1_q;
  assign op2        = op2_q;
  assign ex_pc      = pc_q;
  assign alu_type   = alu_q;
  assign ex_rd_addr = rd_q;
  // bubbles and flushed slots must never write back
  assign ex_rd_we   = valid_q && we_q;
endmodule
